// File: rtl/proc_pkg.sv
// Shared definitions for the 3BC processor run-control and decode logic.
package proc_pkg;

    // Instruction word width, shared with the decode stage.
    localparam int unsigned INSTR_W = 9;

    // Opcode that ends a program.
    localparam logic [INSTR_W-1:0] OP_HALT = 9'b111111111;

    // Run-control sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/start_edge_det.sv
// Registers a level input and flags its rising edge; reusable for bench handshakes.
module start_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic level_q,
    output logic rise
);

    // Previous-cycle copy of the level, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control and fetch sequencer: launches a program run, drives PC clear and
// count-enable, stops on the halt opcode or on a runaway timeout, and records
// the cycle count and the PC at which the run ended.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned         L          = 10,
    parameter int unsigned         W          = INSTR_W,
    parameter logic [W-1:0]        HALT_OP    = OP_HALT,
    parameter int unsigned         CW         = 16,
    parameter logic [CW-1:0]       MAX_CYCLES = 16'hFFF0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [L-1:0]  ProgCtr,
    input  logic [W-1:0]  InstrIn,
    output logic          PcClr,
    output logic          PcEn,
    output logic [W-1:0]  Instr,
    output logic          Done,
    output logic          TimedOut,
    output logic [CW-1:0] CycleCnt,
    output logic [L-1:0]  HaltPc
);

    localparam logic [CW-1:0] LAST_CNT = MAX_CYCLES - 1'b1;

    seq_state_t    state, state_next;
    logic          start_q;
    logic          launch;
    logic          halt;

    logic          done_q, done_next;
    logic          timed_out_q, timed_out_next;
    logic [CW-1:0] cnt_q, cnt_next;
    logic [L-1:0]  halt_pc_q, halt_pc_next;

    start_edge_det u_start_edge (
        .clk     (Clk),
        .rst     (Reset),
        .level   (Start),
        .level_q (start_q),
        .rise    (launch)
    );

    assign halt = (InstrIn == HALT_OP);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result registers: done/timeout flags, cycle counter and end-of-run PC.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
            halt_pc_q   <= '0;
        end else begin
            done_q      <= done_next;
            timed_out_q <= timed_out_next;
            cnt_q       <= cnt_next;
            halt_pc_q   <= halt_pc_next;
        end
    end

    // Next-state, PC control, instruction gating and result updates.
    always_comb begin
        state_next     = state;
        PcClr          = 1'b0;
        PcEn           = 1'b0;
        Instr          = '0;
        done_next      = done_q;
        timed_out_next = timed_out_q;
        cnt_next       = cnt_q;
        halt_pc_next   = halt_pc_q;

        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_next = CLEAR;
                end
            end

            CLEAR: begin
                PcClr          = 1'b1;
                done_next      = 1'b0;
                timed_out_next = 1'b0;
                cnt_next       = '0;
                state_next     = RUN;
            end

            RUN: begin
                Instr = InstrIn;
                // PC holds on the halt word so HaltPc points at it.
                PcEn  = ~halt;
                if (halt) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    halt_pc_next = ProgCtr;
                end else if (cnt_q == LAST_CNT) begin
                    state_next     = DONE;
                    done_next      = 1'b1;
                    timed_out_next = 1'b1;
                    halt_pc_next   = ProgCtr;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (launch) begin
                    state_next = CLEAR;
                end
            end
        endcase
    end

    assign Done     = done_q;
    assign TimedOut = timed_out_q;
    assign CycleCnt = cnt_q;
    assign HaltPc   = halt_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC and ROM.
module tb_fetch_sequencer;
    import proc_pkg::*;

    localparam int unsigned L  = 10;
    localparam int unsigned W  = INSTR_W;
    localparam int unsigned CW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [L-1:0]  ProgCtr;
    logic [W-1:0]  InstrIn;
    logic          PcClr;
    logic          PcEn;
    logic [W-1:0]  Instr;
    logic          Done;
    logic          TimedOut;
    logic [CW-1:0] CycleCnt;
    logic [L-1:0]  HaltPc;

    int n_tests = 0;
    int n_fail  = 0;
    int halt_addr = 5;
    bit no_halt = 1'b0;
    int en_cnt;
    int clr_cnt;

    fetch_sequencer #(
        .L          (L),
        .W          (W),
        .HALT_OP    (OP_HALT),
        .CW         (CW),
        .MAX_CYCLES (16'd8)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .ProgCtr  (ProgCtr),
        .InstrIn  (InstrIn),
        .PcClr    (PcClr),
        .PcEn     (PcEn),
        .Instr    (Instr),
        .Done     (Done),
        .TimedOut (TimedOut),
        .CycleCnt (CycleCnt),
        .HaltPc   (HaltPc)
    );

    always #5 Clk = ~Clk;

    // Program counter: synchronous clear, count-enable, wraps naturally.
    always @(posedge Clk or posedge Reset) begin
        if (Reset)      ProgCtr <= '0;
        else if (PcClr) ProgCtr <= '0;
        else if (PcEn)  ProgCtr <= ProgCtr + 1'b1;
    end

    // ROM: halt word at halt_addr (unless disabled), non-halt filler elsewhere.
    always_comb begin
        if (!no_halt && ProgCtr == halt_addr[L-1:0]) InstrIn = OP_HALT;
        else                                         InstrIn = ProgCtr[W-1:0] ^ 9'h0A5;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Caller raises Start first; first sample is the CLEAR cycle. Start is then
    // driven from hold or from mask bit i after sample i. Returns at DONE.
    task automatic run_to_done(input bit hold, input logic [31:0] mask,
                               output int en, output int clr);
        bit seen_clr;
        bit prev_clr;
        seen_clr = 1'b0;
        prev_clr = 1'b0;
        en  = 0;
        clr = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (prev_clr) check("done_drop_after_clear", Done, 0);
            prev_clr = PcClr;
            if (PcClr) begin
                clr++;
                seen_clr = 1'b1;
            end
            if (PcEn) en++;
            Start = hold ? 1'b1 : mask[i];
            if (seen_clr && !PcClr && Done) return;
        end
        check("run_bound", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        step();
        step();
        check("rst_pcclr", PcClr, 0);
        check("rst_pcen", PcEn, 0);
        check("rst_instr", Instr, 0);
        check("rst_done", Done, 0);
        check("rst_timedout", TimedOut, 0);
        check("rst_cyclecnt", CycleCnt, 0);
        check("rst_haltpc", HaltPc, 0);
        Reset = 1'b0;
        step();
        check("idle_pcen", PcEn, 0);

        // Basic run, halt at address 5, checked cycle by cycle.
        Start = 1'b1;
        step();
        check("clr_pcclr", PcClr, 1);
        check("clr_pcen", PcEn, 0);
        check("clr_instr", Instr, 0);
        Start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("run_pcclr", PcClr, 0);
            check("run_pcen", PcEn, 1);
            check("run_pc", ProgCtr, i);
            check("run_instr", Instr, 9'(i) ^ 9'h0A5);
            step();
        end
        check("halt_pcen", PcEn, 0);
        check("halt_instr", Instr, OP_HALT);
        check("halt_done_not_yet", Done, 0);
        step();
        check("b_done", Done, 1);
        check("b_haltpc", HaltPc, 5);
        check("b_cyclecnt", CycleCnt, 5);
        check("b_timedout", TimedOut, 0);
        check("b_pcen", PcEn, 0);
        check("b_instr", Instr, 0);
        step();
        check("b_done_held", Done, 1);
        check("b_pc_held", ProgCtr, 5);

        // Start held high through the run and beyond: one CLEAR only.
        Start = 1'b1;
        run_to_done(1'b1, 32'd0, en_cnt, clr_cnt);
        check("hold_en", en_cnt, 5);
        check("hold_clr", clr_cnt, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_no_relaunch", PcClr, 0);
        end
        check("hold_done", Done, 1);
        Start = 1'b0;
        step();
        Start = 1'b1;
        step();
        check("relaunch_pcclr", PcClr, 1);
        check("relaunch_done_held", Done, 1);
        Start = 1'b0;
        step();
        check("relaunch_done_dropped", Done, 0);
        check("relaunch_run_pcen", PcEn, 1);
        for (int i = 0; i < 20 && !Done; i++) step();
        check("relaunch_done", Done, 1);
        check("relaunch_haltpc", HaltPc, 5);
        check("relaunch_cyclecnt", CycleCnt, 5);

        // Start pulses during RUN are ignored.
        Start = 1'b1;
        run_to_done(1'b0, 32'b01010, en_cnt, clr_cnt);
        check("pulse_clr", clr_cnt, 1);
        check("pulse_en", en_cnt, 5);
        check("pulse_cyclecnt", CycleCnt, 5);
        Start = 1'b0;
        step();
        step();
        check("pulse_no_relaunch", PcClr, 0);

        // Timeout with no halt word; MAX_CYCLES = 8.
        no_halt = 1'b1;
        Start = 1'b1;
        run_to_done(1'b0, 32'd0, en_cnt, clr_cnt);
        check("to_en", en_cnt, 8);
        check("to_done", Done, 1);
        check("to_timedout", TimedOut, 1);
        check("to_cyclecnt", CycleCnt, 7);
        check("to_haltpc", HaltPc, 7);

        // Halt at address 0: zero enabled cycles.
        no_halt = 1'b0;
        halt_addr = 0;
        Start = 1'b1;
        step();
        check("h0_clr_instr", Instr, 0);
        check("h0_clr_pcclr", PcClr, 1);
        Start = 1'b0;
        step();
        check("h0_run_instr", Instr, OP_HALT);
        check("h0_run_pcen", PcEn, 0);
        check("h0_run_pc", ProgCtr, 0);
        step();
        check("h0_done", Done, 1);
        check("h0_cyclecnt", CycleCnt, 0);
        check("h0_haltpc", HaltPc, 0);
        check("h0_timedout", TimedOut, 0);
        check("h0_done_instr", Instr, 0);

        // Reset mid-run aborts without a Done pulse.
        halt_addr = 5;
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        step();
        check("mr_pcen_before", PcEn, 1);
        Reset = 1'b1;
        #1;
        check("mr_pcen", PcEn, 0);
        check("mr_pcclr", PcClr, 0);
        check("mr_instr", Instr, 0);
        check("mr_done", Done, 0);
        check("mr_cyclecnt", CycleCnt, 0);
        check("mr_haltpc", HaltPc, 0);
        step();
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("mr_idle_done", Done, 0);
        end
        check("mr_idle_pcen", PcEn, 0);
        Start = 1'b1;
        run_to_done(1'b0, 32'd0, en_cnt, clr_cnt);
        check("mr_rerun_en", en_cnt, 5);
        check("mr_rerun_haltpc", HaltPc, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
